dmem_audio_responder: RTL

- Data-memory responder for the pipelined core. It is the memory-side end of the load/store interface.
- Accepts the Execute-stage address, write data and control, and returns ReadDataM during the Memory stage.
- Maps a word RAM plus an audio output port. The audio port is a sample FIFO drained at a programmable sample rate toward the audio DAC/FIR output path.

---
 rtl/dmem_audio_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_audio_responder.sv
// Data-memory responder: word RAM plus a memory-mapped audio sample FIFO that is
// drained toward the DAC path at a programmable sample period.
module dmem_audio_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 16,
  parameter int DIV_RESET  = 1134
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadE,
  input  logic                MemWriteE,
  input  logic [31:0]         ALUResultE,
  input  logic [31:0]         WriteDataE,
  output logic [31:0]         ReadDataM,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                irq_low
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LOW_MARK = CNT_W'(FIFO_DEPTH / 4);

  localparam logic [29:0] AUDIO_WA   = 30'h0000_4000;
  localparam logic [29:0] STATUS_WA  = 30'h0000_4001;
  localparam logic [29:0] DIVIDER_WA = 30'h0000_4002;

  logic [31:0] ram [RAM_WORDS];
  logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [29:0]       word_addr;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_ram;
  logic              sel_audio;
  logic              sel_status;
  logic              sel_divider;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              underrun;
  logic              overflow;

  logic [15:0]       divider;
  logic [15:0]       tick_cnt;
  logic [15:0]       period_m1;
  logic              tick;

  logic              div_wr;
  logic              status_wr;
  logic              push_req;
  logic              push_ok;
  logic              pop;

  logic [31:0]       status_word;
  logic [31:0]       rd_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ALUResultE[1:0];

  assign word_addr   = ALUResultE[31:2];
  assign ram_idx     = ALUResultE[RAM_AW+1:2];
  assign sel_ram     = (ALUResultE[31:RAM_AW+2] == '0);
  assign sel_audio   = (word_addr == AUDIO_WA);
  assign sel_status  = (word_addr == STATUS_WA);
  assign sel_divider = (word_addr == DIVIDER_WA);

  assign div_wr    = MemWriteE && sel_divider;
  assign status_wr = MemWriteE && sel_status;
  assign push_req  = MemWriteE && sel_audio;

  assign fifo_full  = (fifo_count == DEPTH_C);
  assign fifo_empty = (fifo_count == '0);

  // Divider 0 is treated as 1; a divider write restarts the period without a tick.
  assign period_m1 = (divider == 16'd0) ? 16'd0 : divider - 16'd1;
  assign tick      = !div_wr && (tick_cnt == period_m1);

  assign pop     = tick && !fifo_empty;
  assign push_ok = push_req && (!fifo_full || pop);

  always_comb begin
    count_next = fifo_count;
    if (push_ok && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_next = fifo_count - CNT_W'(1);
    end
  end

  assign status_word = {16'h0000, 8'(fifo_count), 4'h0, overflow, underrun,
                        fifo_empty, fifo_full};

  always_comb begin
    rd_data = 32'h0000_0000;
    if (sel_ram) begin
      rd_data = ram[ram_idx];
    end else if (sel_status) begin
      rd_data = status_word;
    end else if (sel_divider) begin
      rd_data = {16'h0000, divider};
    end
  end

  always_ff @(posedge clk) begin
    if (MemWriteE && sel_ram) begin
      ram[ram_idx] <= WriteDataE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= WriteDataE[SAMPLE_W-1:0];
    end
  end

  // Non-blocking read of ram gives read-first behaviour on a same-cycle store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadDataM <= 32'h0000_0000;
    end else if (MemReadE) begin
      ReadDataM <= rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider  <= 16'(DIV_RESET);
      tick_cnt <= 16'd0;
    end else if (div_wr) begin
      divider  <= WriteDataE[15:0];
      tick_cnt <= 16'd0;
    end else if (tick) begin
      tick_cnt <= 16'd0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      irq_low      <= 1'b1;
    end else begin
      fifo_count   <= count_next;
      sample_valid <= pop;
      irq_low      <= (count_next <= LOW_MARK);
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        sample_out <= fifo_mem[rd_ptr];
      end
    end
  end

  // A flag event on the same edge as a STATUS store wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (status_wr) begin
        underrun <= 1'b0;
        overflow <= 1'b0;
      end
      if (tick && fifo_empty) begin
        underrun <= 1'b1;
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
